b_stage_merge_arb: RTL and testbench

//  Two-requester round-robin arbiter/merger in front of the B-stage branch unit.

---
 rtl/b_stage_merge_arb.sv | 193 +++++++++++++++++++
 tb/tb_b_stage_merge_arb.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/b_stage_merge_arb.sv
// Two-requester round-robin merger: grants one upstream packet at a time into a
// one-entry buffer and forwards it to the B stage over a four-phase Send/Ack pair.
module b_stage_merge_arb #(
    parameter int PW    = 38,
    parameter int CNT_W = 16
) (
    input  logic             CP,
    input  logic             MR_N,
    input  logic             Send_in_a,
    input  logic [PW-1:0]    PACKET_IN_a,
    output logic             Ack_out_a,
    input  logic             Send_in_b,
    input  logic [PW-1:0]    PACKET_IN_b,
    output logic             Ack_out_b,
    output logic             Send_out,
    output logic [PW-1:0]    PACKET_OUT,
    input  logic             Ack_in,
    output logic [CNT_W-1:0] GNT_CNT_a,
    output logic [CNT_W-1:0] GNT_CNT_b,
    output logic             PROT_ERR
);

    localparam logic [0:0] I_IDLE = 1'b0;
    localparam logic [0:0] I_ACK  = 1'b1;
    localparam logic [1:0] O_IDLE = 2'd0;
    localparam logic [1:0] O_SEND = 2'd1;
    localparam logic [1:0] O_REL  = 2'd2;

    logic [0:0]       istate_q, istate_d;
    logic [1:0]       ostate_q, ostate_d;
    logic             full_q, full_d;
    logic [PW-1:0]    buf_q, buf_d;
    logic             ack_a_q, ack_a_d;
    logic             ack_b_q, ack_b_d;
    logic             win_q, win_d;
    logic             last_q, last_d;
    logic             send_out_q, send_out_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
    logic             prot_err_q, prot_err_d;
    logic             send_a_prev_q, send_b_prev_q;
    logic             pick_b_s;
    logic             win_send_s;
    logic             err_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Next-state logic for the input (grant) FSM, output (send) FSM and error monitor
    always_comb begin
        istate_d   = istate_q;
        ostate_d   = ostate_q;
        full_d     = full_q;
        buf_d      = buf_q;
        ack_a_d    = ack_a_q;
        ack_b_d    = ack_b_q;
        win_d      = win_q;
        last_d     = last_q;
        send_out_d = send_out_q;
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;
        // last_q=1 means B won last time, so a tie goes to A
        pick_b_s   = Send_in_b & (~Send_in_a | ~last_q);
        win_send_s = win_q ? Send_in_b : Send_in_a;

        case (istate_q)
            I_IDLE: begin
                if (!full_q && (Send_in_a || Send_in_b)) begin
                    win_d    = pick_b_s;
                    last_d   = pick_b_s;
                    full_d   = 1'b1;
                    istate_d = I_ACK;
                    if (pick_b_s) begin
                        buf_d   = PACKET_IN_b;
                        ack_b_d = 1'b1;
                        cnt_b_d = sat_inc(cnt_b_q);
                    end else begin
                        buf_d   = PACKET_IN_a;
                        ack_a_d = 1'b1;
                        cnt_a_d = sat_inc(cnt_a_q);
                    end
                end else begin
                    istate_d = I_IDLE;
                end
            end
            I_ACK: begin
                if (!win_send_s) begin
                    istate_d = I_IDLE;
                    if (win_q) begin
                        ack_b_d = 1'b0;
                    end else begin
                        ack_a_d = 1'b0;
                    end
                end else begin
                    istate_d = I_ACK;
                end
            end
            default: begin
                istate_d = I_IDLE;
                ack_a_d  = 1'b0;
                ack_b_d  = 1'b0;
            end
        endcase

        // full is set only from empty and cleared only in O_REL, so the two FSMs never collide
        case (ostate_q)
            O_IDLE: begin
                if (full_q) begin
                    send_out_d = 1'b1;
                    ostate_d   = O_SEND;
                end else begin
                    ostate_d   = O_IDLE;
                end
            end
            O_SEND: begin
                if (Ack_in) begin
                    send_out_d = 1'b0;
                    ostate_d   = O_REL;
                end else begin
                    ostate_d   = O_SEND;
                end
            end
            O_REL: begin
                if (!Ack_in) begin
                    full_d   = 1'b0;
                    ostate_d = O_IDLE;
                end else begin
                    ostate_d = O_REL;
                end
            end
            default: begin
                send_out_d = 1'b0;
                ostate_d   = O_IDLE;
            end
        endcase

        err_s = ((ostate_q == O_IDLE) && Ack_in)
              | (send_a_prev_q & ~Send_in_a & ~ack_a_q)
              | (send_b_prev_q & ~Send_in_b & ~ack_b_q)
              | (~send_a_prev_q & Send_in_a & ack_a_q)
              | (~send_b_prev_q & Send_in_b & ack_b_q);
        prot_err_d = prot_err_q | err_s;
    end

    // State registers with asynchronous master reset
    always_ff @(posedge CP or negedge MR_N) begin
        if (!MR_N) begin
            istate_q      <= I_IDLE;
            ostate_q      <= O_IDLE;
            full_q        <= 1'b0;
            buf_q         <= {PW{1'b0}};
            ack_a_q       <= 1'b0;
            ack_b_q       <= 1'b0;
            win_q         <= 1'b0;
            last_q        <= 1'b1;
            send_out_q    <= 1'b0;
            cnt_a_q       <= {CNT_W{1'b0}};
            cnt_b_q       <= {CNT_W{1'b0}};
            prot_err_q    <= 1'b0;
            send_a_prev_q <= 1'b0;
            send_b_prev_q <= 1'b0;
        end else begin
            istate_q      <= istate_d;
            ostate_q      <= ostate_d;
            full_q        <= full_d;
            buf_q         <= buf_d;
            ack_a_q       <= ack_a_d;
            ack_b_q       <= ack_b_d;
            win_q         <= win_d;
            last_q        <= last_d;
            send_out_q    <= send_out_d;
            cnt_a_q       <= cnt_a_d;
            cnt_b_q       <= cnt_b_d;
            prot_err_q    <= prot_err_d;
            send_a_prev_q <= Send_in_a;
            send_b_prev_q <= Send_in_b;
        end
    end

    assign Ack_out_a  = ack_a_q;
    assign Ack_out_b  = ack_b_q;
    assign Send_out   = send_out_q;
    assign PACKET_OUT = buf_q;
    assign GNT_CNT_a  = cnt_a_q;
    assign GNT_CNT_b  = cnt_b_q;
    assign PROT_ERR   = prot_err_q;

endmodule

// File: tb/tb_b_stage_merge_arb.sv
// Directed bench for b_stage_merge_arb: expected packets go into a queue when issued,
// and a monitor pops and compares each time Send_out rises.
module tb_b_stage_merge_arb;
    localparam int PW = 38;
    localparam int CW = 4;

    logic          CP = 1'b0;
    logic          MR_N;
    logic          Send_in_a, Send_in_b;
    logic [PW-1:0] PACKET_IN_a, PACKET_IN_b;
    logic          Ack_out_a, Ack_out_b;
    logic          Send_out;
    logic [PW-1:0] PACKET_OUT;
    logic          Ack_in;
    logic [CW-1:0] GNT_CNT_a, GNT_CNT_b;
    logic          PROT_ERR;

    logic          ack_auto, ack_man, resp_en;
    logic [PW-1:0] sbq[$];
    int            checks = 0;
    int            errors = 0;

    assign Ack_in = resp_en ? ack_auto : ack_man;

    always #5 CP = ~CP;

    b_stage_merge_arb #(.PW(PW), .CNT_W(CW)) dut (
        .CP(CP), .MR_N(MR_N),
        .Send_in_a(Send_in_a), .PACKET_IN_a(PACKET_IN_a), .Ack_out_a(Ack_out_a),
        .Send_in_b(Send_in_b), .PACKET_IN_b(PACKET_IN_b), .Ack_out_b(Ack_out_b),
        .Send_out(Send_out), .PACKET_OUT(PACKET_OUT), .Ack_in(Ack_in),
        .GNT_CNT_a(GNT_CNT_a), .GNT_CNT_b(GNT_CNT_b), .PROT_ERR(PROT_ERR)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Downstream B stage: four-phase acknowledge, one cycle per phase
    initial begin
        ack_auto = 1'b0;
        forever begin
            @(negedge CP);
            if (!MR_N) ack_auto = 1'b0;
            else if (Send_out && !ack_auto) ack_auto = 1'b1;
            else if (!Send_out && ack_auto) ack_auto = 1'b0;
        end
    end

    // Scoreboard monitor
    initial begin
        logic          prev;
        logic [PW-1:0] held;
        logic [PW-1:0] exp;
        prev = 1'b0;
        held = '0;
        forever begin
            @(negedge CP);
            if (MR_N && Send_out && !prev) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected actual=%h required=none", PACKET_OUT);
                end else begin
                    exp = sbq.pop_front();
                    if (PACKET_OUT !== exp) begin
                        errors++;
                        $display("FAIL sb_packet actual=%h required=%h", PACKET_OUT, exp);
                    end
                end
                held = PACKET_OUT;
            end else if (MR_N && Send_out && prev) begin
                checks++;
                if (PACKET_OUT !== held) begin
                    errors++;
                    $display("FAIL sb_stable actual=%h required=%h", PACKET_OUT, held);
                end
            end
            prev = MR_N & Send_out;
        end
    end

    task automatic do_reset();
        Send_in_a = 1'b0;
        Send_in_b = 1'b0;
        MR_N      = 1'b0;
        repeat (2) @(negedge CP);
        sbq.delete();
        MR_N = 1'b1;
        @(negedge CP);
    endtask

    // Full four-phase transfer on one upstream port (sel=1 -> B)
    task automatic xfer(input bit sel, input logic [PW-1:0] p);
        int n;
        if (sel) begin PACKET_IN_b = p; Send_in_b = 1'b1; end
        else     begin PACKET_IN_a = p; Send_in_a = 1'b1; end
        n = 0;
        while ((sel ? Ack_out_b : Ack_out_a) !== 1'b1 && n < 400) begin
            @(negedge CP);
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL ack_rise_timeout sel=%0d actual=0 required=1", sel);
        end
        if (sel) Send_in_b = 1'b0;
        else     Send_in_a = 1'b0;
        n = 0;
        while ((sel ? Ack_out_b : Ack_out_a) !== 1'b0 && n < 400) begin
            @(negedge CP);
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL ack_fall_timeout sel=%0d actual=1 required=0", sel);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || Send_out || Ack_in) && n < 400) begin
            @(negedge CP);
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", sbq.size());
        end
        repeat (3) @(negedge CP);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        MR_N = 1'b1; Send_in_a = 1'b0; Send_in_b = 1'b0;
        PACKET_IN_a = '0; PACKET_IN_b = '0; ack_man = 1'b0; resp_en = 1'b1;
        #2 MR_N = 1'b0;
        repeat (2) @(negedge CP);
        chk("rst_ack_a", Ack_out_a, 1'b0);
        chk("rst_ack_b", Ack_out_b, 1'b0);
        chk("rst_send_out", Send_out, 1'b0);
        chk("rst_packet", PACKET_OUT, 38'h0);
        chk("rst_cnt_a", GNT_CNT_a, 4'h0);
        chk("rst_cnt_b", GNT_CNT_b, 4'h0);
        chk("rst_prot", PROT_ERR, 1'b0);
        MR_N = 1'b1;
        @(negedge CP);

        // Reset while a packet is being sent downstream
        resp_en = 1'b0;
        sbq.push_back(38'h1C_DEAD_BEEF);
        xfer(1'b0, 38'h1C_DEAD_BEEF);
        for (int i = 0; i < 10 && !Send_out; i++) @(negedge CP);
        chk("t1_send_before_rst", Send_out, 1'b1);
        MR_N = 1'b0;
        #1;
        chk("t1_send_out", Send_out, 1'b0);
        chk("t1_packet", PACKET_OUT, 38'h0);
        chk("t1_cnt_a", GNT_CNT_a, 4'h0);
        chk("t1_ack_a", Ack_out_a, 1'b0);
        @(negedge CP);
        MR_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CP);
            chk("t1_no_send", Send_out, 1'b0);
        end
        resp_en = 1'b1;

        // Single A transfer with cycle-exact latency
        do_reset();
        sbq.push_back(38'h2A_5555_1234);
        PACKET_IN_a = 38'h2A_5555_1234;
        Send_in_a = 1'b1;
        @(negedge CP);
        chk("t2_ack_e1", Ack_out_a, 1'b1);
        chk("t2_send_e1", Send_out, 1'b0);
        Send_in_a = 1'b0;
        @(negedge CP);
        chk("t2_send_e2", Send_out, 1'b1);
        chk("t2_packet_e2", PACKET_OUT, 38'h2A_5555_1234);
        chk("t2_cnt_a", GNT_CNT_a, 4'h1);
        chk("t2_ack_b", Ack_out_b, 1'b0);
        drain();

        // Tie from reset: strict alternation starting with A
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sbq.push_back({6'h0A, 32'(i)});
            sbq.push_back({6'h0B, 32'(i)});
        end
        fork
            begin
                for (int i = 0; i < 4; i++) xfer(1'b0, {6'h0A, 32'(i)});
            end
            begin
                for (int j = 0; j < 4; j++) xfer(1'b1, {6'h0B, 32'(j)});
            end
        join
        drain();
        chk("t3_cnt_a", GNT_CNT_a, 4'h4);
        chk("t3_cnt_b", GNT_CNT_b, 4'h4);

        // Backpressure: downstream stalls 20 cycles while B waits
        do_reset();
        resp_en = 1'b0;
        sbq.push_back(38'h3F_0000_0001);
        xfer(1'b0, 38'h3F_0000_0001);
        for (int i = 0; i < 10 && !Send_out; i++) @(negedge CP);
        sbq.push_back(38'h15_AAAA_0F0F);
        PACKET_IN_b = 38'h15_AAAA_0F0F;
        Send_in_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CP);
            chk("t4_ack_b_low", Ack_out_b, 1'b0);
            chk("t4_send_hold", Send_out, 1'b1);
            chk("t4_packet_hold", PACKET_OUT, 38'h3F_0000_0001);
        end
        resp_en = 1'b1;
        xfer(1'b1, 38'h15_AAAA_0F0F);
        drain();
        chk("t4_cnt_b", GNT_CNT_b, 4'h1);

        // Grant counter saturation at 4'hF
        do_reset();
        for (int i = 0; i < 17; i++) begin
            sbq.push_back({6'h05, 32'(i)});
            xfer(1'b0, {6'h05, 32'(i)});
            if (i == 13) chk("t5_cnt_14", GNT_CNT_a, 4'hE);
            if (i == 14) chk("t5_cnt_15", GNT_CNT_a, 4'hF);
        end
        drain();
        chk("t5_cnt_sat", GNT_CNT_a, 4'hF);
        chk("t5_cnt_b", GNT_CNT_b, 4'h0);
        chk("t5_no_prot", PROT_ERR, 1'b0);

        // Ack_in without a send raises a sticky protocol error
        do_reset();
        resp_en = 1'b0;
        ack_man = 1'b1;
        @(negedge CP);
        chk("t6_prot_set", PROT_ERR, 1'b1);
        ack_man = 1'b0;
        repeat (3) @(negedge CP);
        chk("t6_prot_sticky", PROT_ERR, 1'b1);
        MR_N = 1'b0;
        #1;
        chk("t6_prot_clear", PROT_ERR, 1'b0);
        @(negedge CP);
        MR_N = 1'b1;
        @(negedge CP);
        resp_en = 1'b1;
        repeat (2) @(negedge CP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
